// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter among NUM_REQ requesters,
// with optional per-grant bursts and a watchdog that abandons a stuck frame.
module uart_tx_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 4,
    parameter int TIMEOUT    = 4096
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ack,
    output logic [DATA_WIDTH-1:0]         tx_din,
    output logic                          tx_start,
    input  logic                          tx_done_tick,
    output logic                          busy,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id,
    output logic                          timeout_err
);
    localparam int IDX_W   = $clog2(NUM_REQ);
    localparam int CAND_W  = IDX_W + 1;
    localparam int BURST_W = $clog2(MAX_BURST + 1);
    localparam int WD_W    = $clog2(TIMEOUT + 1);

    localparam logic [IDX_W-1:0]   LAST_IDX   = IDX_W'(NUM_REQ - 1);
    localparam logic [BURST_W-1:0] BURST_LAST = BURST_W'(MAX_BURST - 1);
    localparam logic [WD_W-1:0]    WD_LIMIT   = WD_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        WAIT
    } state_t;

    state_t                state_q, state_d;
    logic [IDX_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic [BURST_W-1:0]    burst_cnt_q, burst_cnt_d;
    logic [WD_W-1:0]       watchdog_q, watchdog_d;
    logic [DATA_WIDTH-1:0] tx_din_d;
    logic [IDX_W-1:0]      grant_id_d;
    logic                  timeout_err_d;
    logic                  tx_start_d;
    logic [NUM_REQ-1:0]    req_ack_d;
    logic                  busy_d;
    logic [IDX_W-1:0]      next_ptr;

    logic [DATA_WIDTH-1:0] req_word [NUM_REQ];

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            req_word[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // First pending requester at or above rr_ptr, wrapping past NUM_REQ-1.
    logic             sel_found;
    logic [IDX_W-1:0] sel_idx;
    logic [CAND_W-1:0] cand;

    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, rr_ptr_q} + CAND_W'(k);
            if (cand >= CAND_W'(NUM_REQ)) begin
                cand = cand - CAND_W'(NUM_REQ);
            end
            if (!sel_found && req_valid[cand[IDX_W-1:0]]) begin
                sel_found = 1'b1;
                sel_idx   = cand[IDX_W-1:0];
            end
        end
    end

    assign next_ptr = (grant_id == LAST_IDX) ? '0 : grant_id + 1'b1;

    always_comb begin
        // NOTE: every variable is given its default before the case so no path can infer a latch.
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        burst_cnt_d   = burst_cnt_q;
        watchdog_d    = watchdog_q;
        tx_din_d      = tx_din;
        grant_id_d    = grant_id;
        timeout_err_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (sel_found) begin
                    tx_din_d    = req_word[sel_idx];
                    grant_id_d  = sel_idx;
                    burst_cnt_d = '0;
                    state_d     = LAUNCH;
                end
            end
            LAUNCH: begin
                watchdog_d = '0;
                state_d    = WAIT;
            end
            WAIT: begin
                watchdog_d = watchdog_q + 1'b1;
                if (tx_done_tick) begin
                    if (req_valid[grant_id] && (burst_cnt_q < BURST_LAST)) begin
                        tx_din_d    = req_word[grant_id];
                        burst_cnt_d = burst_cnt_q + 1'b1;
                        state_d     = LAUNCH;
                    end else begin
                        rr_ptr_d = next_ptr;
                        state_d  = IDLE;
                    end
                end else if (watchdog_q == WD_LIMIT) begin
                    // The aborted word was already acked, so it is simply dropped.
                    timeout_err_d = 1'b1;
                    rr_ptr_d      = next_ptr;
                    state_d       = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        tx_start_d = (state_d == LAUNCH);
        req_ack_d  = tx_start_d ? (NUM_REQ'(1) << grant_id_d) : '0;
        busy_d     = (state_d != IDLE);
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            burst_cnt_q <= '0;
            watchdog_q  <= '0;
            tx_din      <= '0;
            grant_id    <= '0;
            timeout_err <= 1'b0;
            tx_start    <= 1'b0;
            req_ack     <= '0;
            busy        <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            burst_cnt_q <= burst_cnt_d;
            watchdog_q  <= watchdog_d;
            tx_din      <= tx_din_d;
            grant_id    <= grant_id_d;
            timeout_err <= timeout_err_d;
            tx_start    <= tx_start_d;
            req_ack     <= req_ack_d;
            busy        <= busy_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed vector table, hand-written
// corner sequences, then random traffic against a transaction-level model.
module tb_uart_tx_arbiter;
    localparam int NR  = 4;
    localparam int DW  = 8;
    localparam int MB  = 4;
    localparam int TMO = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic [NR-1:0]     req_valid;
    logic [NR*DW-1:0]  req_data;
    logic [NR-1:0]     req_ack;
    logic [DW-1:0]     tx_din;
    logic              tx_start;
    logic              tx_done_tick;
    logic              busy;
    logic [1:0]        grant_id;
    logic              timeout_err;

    int checks   = 0;
    int failures = 0;

    uart_tx_arbiter #(
        .NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_BURST(MB), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
        .req_ack(req_ack), .tx_din(tx_din), .tx_start(tx_start),
        .tx_done_tick(tx_done_tick), .busy(busy), .grant_id(grant_id),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL tb_watchdog simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Output bundle: {start, ack[3:0], din[7:0], busy, grant[1:0], timeout_err}
    function automatic logic [31:0] pack(input logic s, input logic [3:0] a, input logic [7:0] d,
                                         input logic b, input logic [1:0] g, input logic t);
        return {15'd0, s, a, d, b, g, t};
    endfunction

    function automatic logic [31:0] outs();
        return pack(tx_start, req_ack, tx_din, busy, grant_id, timeout_err);
    endfunction

    task automatic drive(input logic [3:0] v, input logic [31:0] d, input logic dn);
        req_valid    = v;
        req_data     = d;
        tx_done_tick = dn;
    endtask

    task automatic wait_start(input string name, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (tx_start === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL %s no tx_start within 40 cycles", name);
        end
    endtask

    // Called at the negedge of the launch cycle: drop requests, complete the frame.
    task automatic finish_tx();
        drive(4'b0000, req_data, 1'b0);
        @(negedge clk);
        tx_done_tick = 1'b1;
        @(negedge clk);
        tx_done_tick = 1'b0;
    endtask

    typedef struct {
        logic [3:0]  valid;
        logic [31:0] data;
        logic        done;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [19];

    // Reference model state (transaction level)
    logic [7:0]  rq [NR][$];
    int          m_owner;
    int          m_burst;
    int          m_wait;
    int          m_ptr;
    bit          m_launch;
    logic [1:0]  m_grant;
    logic [7:0]  m_din;
    logic [31:0] m_exp;

    task automatic model_step(input logic [3:0] v, input logic [31:0] d, input logic dn);
        logic t;
        bit   found;
        t = 1'b0;
        found = 1'b0;
        if (m_owner < 0) begin
            for (int k = 0; k < NR; k++) begin
                int idx;
                idx = (m_ptr + k) % NR;
                if (!found && v[idx]) begin
                    found   = 1'b1;
                    m_owner = idx;
                end
            end
            if (found) begin
                m_burst  = 0;
                m_din    = d[m_owner*DW +: DW];
                m_launch = 1'b1;
            end
        end else if (m_launch) begin
            m_launch = 1'b0;
            m_wait   = 0;
        end else if (dn) begin
            if (v[m_owner] && (m_burst < MB - 1)) begin
                m_burst++;
                m_din    = d[m_owner*DW +: DW];
                m_launch = 1'b1;
            end else begin
                m_ptr   = (m_owner + 1) % NR;
                m_owner = -1;
            end
        end else if (m_wait == TMO - 1) begin
            t       = 1'b1;
            m_ptr   = (m_owner + 1) % NR;
            m_owner = -1;
        end else begin
            m_wait++;
        end
        if (m_owner >= 0) m_grant = 2'(m_owner);
        m_exp = pack(m_launch, m_launch ? 4'(1 << m_owner) : 4'b0000, m_din,
                     m_owner >= 0, m_grant, t);
    endtask

    initial begin
        bit ok;
        logic [3:0]  rv;
        logic [31:0] rd;
        logic        rdn;
        int          tx_cnt;

        vecs[0]  = '{4'b0000, 32'h0000_0000, 1'b1, pack(0, 4'b0000, 8'h00, 0, 2'd0, 0)};
        vecs[1]  = '{4'b0000, 32'h0000_0000, 1'b0, pack(0, 4'b0000, 8'h00, 0, 2'd0, 0)};
        vecs[2]  = '{4'b0100, 32'h00A5_0000, 1'b0, pack(1, 4'b0100, 8'hA5, 1, 2'd2, 0)};
        vecs[3]  = '{4'b0000, 32'h00A5_0000, 1'b0, pack(0, 4'b0000, 8'hA5, 1, 2'd2, 0)};
        vecs[4]  = '{4'b0000, 32'h00A5_0000, 1'b0, pack(0, 4'b0000, 8'hA5, 1, 2'd2, 0)};
        vecs[5]  = '{4'b0000, 32'h00A5_0000, 1'b1, pack(0, 4'b0000, 8'hA5, 0, 2'd2, 0)};
        vecs[6]  = '{4'b0000, 32'h3333_3333, 1'b0, pack(0, 4'b0000, 8'hA5, 0, 2'd2, 0)};
        vecs[7]  = '{4'b1111, 32'h4332_2110, 1'b0, pack(1, 4'b1000, 8'h43, 1, 2'd3, 0)};
        vecs[8]  = '{4'b0111, 32'h0032_2110, 1'b0, pack(0, 4'b0000, 8'h43, 1, 2'd3, 0)};
        vecs[9]  = '{4'b0111, 32'h0032_2110, 1'b1, pack(0, 4'b0000, 8'h43, 0, 2'd3, 0)};
        vecs[10] = '{4'b0111, 32'h0032_2110, 1'b0, pack(1, 4'b0001, 8'h10, 1, 2'd0, 0)};
        vecs[11] = '{4'b0110, 32'h0032_2100, 1'b0, pack(0, 4'b0000, 8'h10, 1, 2'd0, 0)};
        vecs[12] = '{4'b0110, 32'h0032_2100, 1'b1, pack(0, 4'b0000, 8'h10, 0, 2'd0, 0)};
        vecs[13] = '{4'b0110, 32'h0032_2100, 1'b0, pack(1, 4'b0010, 8'h21, 1, 2'd1, 0)};
        vecs[14] = '{4'b0100, 32'h0032_0000, 1'b1, pack(0, 4'b0000, 8'h21, 1, 2'd1, 0)};
        vecs[15] = '{4'b0100, 32'h0032_0000, 1'b1, pack(0, 4'b0000, 8'h21, 0, 2'd1, 0)};
        vecs[16] = '{4'b0100, 32'h0032_0000, 1'b0, pack(1, 4'b0100, 8'h32, 1, 2'd2, 0)};
        vecs[17] = '{4'b0000, 32'h0032_0000, 1'b0, pack(0, 4'b0000, 8'h32, 1, 2'd2, 0)};
        vecs[18] = '{4'b0000, 32'h0032_0000, 1'b1, pack(0, 4'b0000, 8'h32, 0, 2'd2, 0)};

        reset = 1'b1;
        drive(4'b0000, 32'h0, 1'b0);
        #12;
        check("reset_state", outs(), 32'h0);
        @(negedge clk);
        reset = 1'b0;

        for (int r = 0; r < 19; r++) begin
            drive(vecs[r].valid, vecs[r].data, vecs[r].done);
            @(negedge clk);
            check($sformatf("vec%0d", r), outs(), vecs[r].exp);
        end
        drive(4'b0000, 32'h0, 1'b0);

        // Burst: requester 1 always valid, requester 2 waiting; rr_ptr is 3 here.
        drive(4'b0110, {8'h00, 8'hC2, 8'hB0, 8'h00}, 1'b0);
        for (int k = 0; k < 4; k++) begin
            wait_start($sformatf("burst_start%0d", k), ok);
            if (!ok) break;
            check($sformatf("burst_grant%0d", k), {30'd0, grant_id}, 32'd1);
            check($sformatf("burst_din%0d", k), {24'd0, tx_din}, 32'(8'hB0 + k));
            check($sformatf("burst_ack%0d", k), {28'd0, req_ack}, 32'b0010);
            req_data[15:8] = 8'(8'hB0 + k + 1);
            @(negedge clk);
            @(negedge clk);
            tx_done_tick = 1'b1;
            @(negedge clk);
            tx_done_tick = 1'b0;
            if (k < 3) check($sformatf("burst_gap%0d", k), {31'd0, tx_start}, 32'd1);
            else check("burst_end_idle", {31'd0, busy}, 32'd0);
        end
        wait_start("burst_rotate", ok);
        check("burst_rotate_grant", {30'd0, grant_id}, 32'd2);
        check("burst_rotate_din", {24'd0, tx_din}, 32'hC2);
        finish_tx();

        // Timeout: rr_ptr is 3, requester 0 wins, transmitter never completes.
        drive(4'b0001, 32'h0000_005A, 1'b0);
        wait_start("tmo_start", ok);
        drive(4'b0000, 32'h0000_005A, 1'b0);
        for (int c = 1; c <= 18; c++) begin
            @(negedge clk);
            if (c == 16) check("tmo_before", {30'd0, busy, timeout_err}, 32'b10);
            if (c == 17) check("tmo_pulse", {30'd0, busy, timeout_err}, 32'b01);
            if (c == 18) check("tmo_after", {30'd0, busy, timeout_err}, 32'b00);
        end
        drive(4'b1111, 32'h4433_2211, 1'b0);
        wait_start("tmo_rotate", ok);
        check("tmo_rotate_grant", {30'd0, grant_id}, 32'd1);
        finish_tx();

        // Reset in the middle of a transaction with rr_ptr = 2.
        drive(4'b0100, 32'h0077_0000, 1'b0);
        wait_start("rst_start", ok);
        #2 reset = 1'b1;
        #1 check("rst_mid_tx", outs(), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        drive(4'b1111, 32'h4433_2211, 1'b0);
        wait_start("rst_regrant", ok);
        check("rst_regrant", outs(), pack(1, 4'b0001, 8'h11, 1, 2'd0, 0));
        finish_tx();

        // Random traffic against the reference model.
        reset = 1'b1;
        drive(4'b0000, 32'h0, 1'b0);
        @(negedge clk);
        reset    = 1'b0;
        m_owner  = -1;
        m_burst  = 0;
        m_wait   = 0;
        m_ptr    = 0;
        m_launch = 1'b0;
        m_grant  = 2'd0;
        m_din    = 8'h00;
        m_exp    = 32'h0;
        tx_cnt   = 0;
        for (int i = 0; i < NR; i++) rq[i].delete();
        for (int c = 0; c < 2000; c++) begin
            check($sformatf("rand_cycle%0d", c), outs(), m_exp);
            for (int i = 0; i < NR; i++) begin
                if (req_ack[i] === 1'b1 && rq[i].size() > 0) void'(rq[i].pop_front());
            end
            rdn = 1'b0;
            if (tx_start === 1'b1) begin
                tx_cnt = ($urandom_range(0, 9) == 0) ? 25 : int'($urandom_range(1, 6));
            end else if (tx_cnt > 0) begin
                tx_cnt--;
                if (tx_cnt == 0) rdn = 1'b1;
            end
            if ($urandom_range(0, 29) == 0) rdn = 1'b1;
            for (int i = 0; i < NR; i++) begin
                if (rq[i].size() < 4 && $urandom_range(0, 7) == 0) rq[i].push_back(8'($urandom));
            end
            for (int i = 0; i < NR; i++) begin
                rv[i] = (rq[i].size() > 0);
                rd[i*DW +: DW] = rv[i] ? rq[i][0] : 8'($urandom);
            end
            drive(rv, rd, rdn);
            model_step(rv, rd, rdn);
            @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one UART transmitter between NUM_REQ independent requesters using round-robin arbitration.
- Latches the granted requester's word, drives it onto the transmitter's din with a single-cycle tx_start, then waits for tx_done_tick.
- Optionally lets the winner send a short burst of words before rotating to the next requester.
- Sits between the client logic and the transmitter; a watchdog recovers the arbiter if the transmitter never completes.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_WIDTH, 8, word width; must match the transmitter's DATA_WIDTH.
- MAX_BURST, 4, maximum consecutive words per grant (>=1).
- TIMEOUT, 4096, clk cycles allowed in WAIT before an abort.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester word available; held until acked.
- req_data  in  NUM_REQ*DATA_WIDTH  requester i's word in bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_ack  out  NUM_REQ  one-cycle pulse; word from requester i consumed.
- tx_din  out  DATA_WIDTH  word presented to the transmitter din.
- tx_start  out  1  one-cycle start pulse to the transmitter.
- tx_done_tick  in  1  transmitter stop-bit completion pulse.
- busy  out  1  high in LAUNCH and WAIT.
- grant_id  out  $clog2(NUM_REQ)  index of the current or last owner.
- timeout_err  out  1  one-cycle pulse when a WAIT abort occurs.

Behaviour:
- Reset values (asynchronous, immediate): state=IDLE, all outputs 0, rr_ptr=0, burst_cnt=0, watchdog=0.
- All outputs are registered; there is no combinational path from inputs to outputs.
- States: IDLE, LAUNCH, WAIT.
- IDLE:
  - If any req_valid bit is set, select the first set bit searching upward from rr_ptr with wrap (rr_ptr, rr_ptr+1, ..., NUM_REQ-1, 0, ...).
  - Latch the selected word into tx_din, set grant_id to that index, set burst_cnt=0, go to LAUNCH.
  - If no request is pending, remain in IDLE; tx_din holds its last value.
- LAUNCH (exactly one cycle):
  - tx_start=1 and req_ack[grant_id]=1 in the same cycle; go to WAIT with watchdog cleared.
  - Latency: request seen in IDLE at cycle T gives tx_start and ack at T+1.
- WAIT:
  - tx_din stays stable and tx_start=0; the watchdog increments every cycle.
  - On tx_done_tick, if req_valid[grant_id]=1 and burst_cnt<MAX_BURST-1:
    - latch the new req_data word of grant_id, increment burst_cnt, go to LAUNCH.
    - The next tx_start occurs the cycle after tx_done_tick.
  - On tx_done_tick otherwise: rr_ptr = grant_id+1 (wrapping at NUM_REQ), go to IDLE.
  - If the watchdog reaches TIMEOUT-1 without tx_done_tick:
    - pulse timeout_err, advance rr_ptr as above, go to IDLE.
    - No retry; the word is considered lost (it was already acked).
- tx_done_tick outside WAIT is ignored.
- req_valid deasserting before ack is a protocol violation; behaviour is undefined and not checked.
- With MAX_BURST=1 the arbiter rotates after every word.
- A requester that drops req_valid mid-burst ends the burst at the next tx_done_tick.
- Reset mid-WAIT: return immediately to reset values. The transmitter shares the reset, so no half frame is resumed.
- grant_id holds after returning to IDLE until the next grant.

Test Plan:
- Reset asserted mid-WAIT -> within the same cycle busy=0, tx_start=0, req_ack=0; the next request after release is granted starting from index 0.
- Single requester: req_valid=4'b0100 with data 0xA5 at cycle 10 -> tx_start=1, req_ack=4'b0100, tx_din=0xA5 at cycle 11; busy until 1 cycle after tx_done_tick.
- Round robin: all four valid with data 0x10/0x21/0x32/0x43, MAX_BURST=1 -> transmitted order 0x10, 0x21, 0x32, 0x43, then 0x10 again; exactly one ack per word.
- Burst: requester 1 always valid, requester 2 valid, MAX_BURST=4 -> four words from requester 1, then requester 2 granted. The start-to-start gap inside the burst is exactly 1 cycle after each tx_done_tick.
- Timeout: TIMEOUT=16, tx_done_tick held 0 -> timeout_err pulses 16 cycles after the WAIT entry cycle; state returns to IDLE and rr_ptr advances by one.
- Stray tx_done_tick in IDLE with no requests -> no state change, no ack, busy=0.
